// File: rtl/fpau_issue_queue.sv
// Issue and result register stages around the combinational fp add/sub datapath.
// Requests queue in a small circular FIFO. One request at a time sits in the issue
// register driving as_*, and the datapath sum is captured into the result register
// for a valid/ready handoff downstream.
module fpau_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_A,
  input  logic [31:0]      in_B,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      as_A,
  output logic [31:0]      as_B,
  output logic             as_sub_or_add,
  input  logic [31:0]      as_S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_S,
  output logic [TAG_W-1:0] out_tag,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             sub;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             mem [DEPTH];
  req_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             iss_v;
  logic [TAG_W-1:0] iss_tag;
  logic             res_v;
  logic             nonempty;
  logic             push;
  logic             pop;
  logic             res_adv;
  logic             issue_adv;

  // in_ready ignores a same-cycle pop, so a full FIFO never sees push and pop together
  assign in_ready  = (count < CW'(DEPTH));
  assign nonempty  = (count != '0);
  assign push      = in_valid & in_ready;
  assign res_adv   = ~res_v | out_ready;
  assign issue_adv = ~iss_v | res_adv;
  assign pop       = nonempty & issue_adv;
  assign head      = mem[rd_ptr];
  assign out_valid = res_v;

  // FIFO storage; a push in a flush cycle is discarded
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= '{a: in_A, b: in_B, sub: in_sub, tag: in_tag};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Issue register: loads the FIFO head whenever it can move, otherwise holds as_* steady
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v         <= 1'b0;
      as_A          <= '0;
      as_B          <= '0;
      as_sub_or_add <= 1'b0;
      iss_tag       <= '0;
    end else if (flush) begin
      iss_v <= 1'b0;
    end else if (issue_adv) begin
      iss_v <= nonempty;
      if (nonempty) begin
        as_A          <= head.a;
        as_B          <= head.b;
        as_sub_or_add <= head.sub;
        iss_tag       <= head.tag;
      end
    end
  end

  // Result register: captures the datapath output whenever the downstream slot is free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_v   <= 1'b0;
      out_S   <= '0;
      out_tag <= '0;
    end else if (flush) begin
      res_v <= 1'b0;
    end else if (res_adv) begin
      res_v   <= iss_v;
      out_S   <= as_S;
      out_tag <= iss_tag;
    end
  end

endmodule

// File: tb/tb_fpau_issue_queue.sv
// Scoreboard bench for fpau_issue_queue with an integer-valued float datapath stub.
module tb_fpau_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_A;
  logic [31:0]      in_B;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      as_A;
  logic [31:0]      as_B;
  logic             as_sub_or_add;
  logic [31:0]      as_S;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_S;
  logic [TAG_W-1:0] out_tag;
  logic [CW-1:0]    count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0]      s;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Integer-valued single precision helpers (exact for magnitudes below 2^24)
  function automatic int f2i(logic [31:0] f);
    int p;
    int v;
    if (f[30:0] == 31'd0) return 0;
    p = int'(f[30:23]) - 127;
    if (p < 0 || p > 23) return 0;
    v = int'({8'd0, 1'b1, f[22:0]}) >>> (23 - p);
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] i2f(int v);
    int a;
    int p;
    logic [31:0] m;
    if (v == 0) return 32'd0;
    a = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (a >= (1 << i)) p = i;
    m = 32'(a) << (23 - p);
    return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic logic [31:0] fp_addsub(logic [31:0] a, logic [31:0] b, logic sub);
    return i2f(sub ? f2i(a) - f2i(b) : f2i(a) + f2i(b));
  endfunction

  assign as_S = fp_addsub(as_A, as_B, as_sub_or_add);

  fpau_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_sub(in_sub), .in_tag(in_tag),
    .as_A(as_A), .as_B(as_B), .as_sub_or_add(as_sub_or_add), .as_S(as_S),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_S(out_S), .out_tag(out_tag), .count(count)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(logic [TAG_W-1:0] tag);
    in_A   = i2f(int'($urandom_range(0, 1000)));
    in_B   = i2f(int'($urandom_range(0, 1000)));
    in_sub = 1'($urandom_range(0, 1));
    in_tag = tag;
  endtask

  task automatic wait_valid(string nm);
    int b = 0;
    while (!out_valid && b < 20) begin
      step();
      b++;
    end
    chk(nm, 32'(out_valid), 32'd1);
  endtask

  // Monitor: inputs change just after posedge, so negedge shows the values used at the next edge
  logic             hold_chk = 1'b0;
  logic [31:0]      held_S;
  logic [TAG_W-1:0] held_tag;
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      sb.delete();
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_S", out_S, held_S);
        chk("hold_tag", 32'(out_tag), 32'(held_tag));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got tag %0d S 0x%08h expected no result", out_tag, out_S);
        end else begin
          e = sb.pop_front();
          chk("result_S", out_S, e.s);
          chk("result_tag", 32'(out_tag), 32'(e.tag));
        end
      end
      if (in_valid && in_ready) sb.push_back('{s: fp_addsub(in_A, in_B, in_sub), tag: in_tag});
      hold_chk = out_valid && !out_ready;
      held_S   = out_S;
      held_tag = out_tag;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int vc;
    logic [31:0] sv_A;
    logic [31:0] sv_S;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_A = '0; in_B = '0; in_sub = 1'b0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_as_A", as_A, 32'd0);
    chk("rst_as_B", as_B, 32'd0);
    chk("rst_as_sub", 32'(as_sub_or_add), 32'd0);
    chk("rst_out_S", out_S, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);

    // 1.0 + 2.0, latency check
    out_ready = 1'b1;
    in_valid = 1'b1; in_A = 32'h3F80_0000; in_B = 32'h4000_0000; in_sub = 1'b0; in_tag = 4'd1;
    step();
    in_valid = 1'b0;
    chk("t1_count_e0", 32'(count), 32'd1);
    chk("t1_valid_e0", 32'(out_valid), 32'd0);
    step();
    chk("t1_count_e1", 32'(count), 32'd0);
    chk("t1_as_A", as_A, 32'h3F80_0000);
    chk("t1_as_B", as_B, 32'h4000_0000);
    chk("t1_valid_e1", 32'(out_valid), 32'd0);
    step();
    chk("t1_valid_e2", 32'(out_valid), 32'd1);
    chk("t1_out_S", out_S, 32'h4040_0000);
    chk("t1_out_tag", 32'(out_tag), 32'd1);
    step();
    chk("t1_popped", 32'(out_valid), 32'd0);

    // 3.0 - 1.0
    in_valid = 1'b1; in_A = 32'h4040_0000; in_B = 32'h3F80_0000; in_sub = 1'b1; in_tag = 4'd2;
    step();
    in_valid = 1'b0;
    wait_valid("t2_valid");
    chk("t2_out_S", out_S, 32'h4000_0000);
    chk("t2_out_tag", 32'(out_tag), 32'd2);
    step();

    // Backpressure: 7 attempts, capacity DEPTH+2
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      rand_req(TAG_W'(3 + i));
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd6);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_tag", 32'(out_tag), 32'd3);
    sv_A = as_A;
    sv_S = out_S;
    repeat (3) step();
    chk("bp_as_A_stable", as_A, sv_A);
    chk("bp_out_S_stable", out_S, sv_S);
    chk("bp_count_hold", 32'(count), 32'd4);
    out_ready = 1'b1;
    vc = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) vc++;
      step();
    end
    chk("bp_drain_cycles", 32'(vc), 32'd6);
    chk("bp_drained_valid", 32'(out_valid), 32'd0);
    chk("bp_drained_count", 32'(count), 32'd0);

    // Streaming at full throughput
    vc = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      rand_req(TAG_W'(i));
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      if (out_valid) vc++;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) vc++;
      step();
    end
    chk("stream_results", 32'(vc), 32'd20);

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_req(TAG_W'($urandom_range(0, 15)));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    begin
      int b = 0;
      while ((count != '0 || out_valid) && b < 20) begin
        step();
        b++;
      end
    end
    chk("rand_drained", 32'(out_valid), 32'd0);

    // Flush with 3 queued, issue and result stages full
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      rand_req(TAG_W'(i));
      step();
    end
    chk("fl_pre_count", 32'(count), 32'd3);
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    rand_req(4'd15);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    vc = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) vc++;
      step();
    end
    chk("fl_no_stale", 32'(vc), 32'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      rand_req(TAG_W'(i + 5));
      step();
    end
    in_valid = 1'b0;
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    in_valid = 1'b1; in_A = i2f(5); in_B = i2f(7); in_sub = 1'b0; in_tag = 4'd9;
    step();
    in_valid = 1'b0;
    wait_valid("ar_post_valid");
    chk("ar_post_S", out_S, 32'h4140_0000);
    chk("ar_post_tag", 32'(out_tag), 32'd9);
    step();
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpau_issue_queue.md
# fpau_issue_queue

Operand issue and result capture stage wrapped around the combinational 32-bit floating-point add/sub datapath. It buffers incoming operation requests (A, B, add/sub select, tag) in a small FIFO and drives one request at a time into the datapath from an issue register. It captures the datapath result into a result register and presents it downstream with a valid/ready handshake, so the combinational adder can sit between two register stages at full throughput.

## Interface
- DEPTH, default 4: number of FIFO entries; must be a power of 2 and at least 2.
- TAG_W, default 4: width of the user tag carried alongside each request.
- CW, default $clog2(DEPTH+1): width of the occupancy count.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO, issue stage and result stage.
- in_valid  in  1  request present.
- in_ready  out  1  high when count < DEPTH; a request is accepted on an edge where in_valid & in_ready.
- in_A  in  32  IEEE-754 single operand A.
- in_B  in  32  IEEE-754 single operand B.
- in_sub  in  1  0 = A+B, 1 = A−B.
- in_tag  in  TAG_W  opaque tag returned with the result.
- as_A  out  32  issue-register operand A to the datapath.
- as_B  out  32  issue-register operand B to the datapath.
- as_sub_or_add  out  1  issue-register op select to the datapath.
- as_S  in  32  combinational result from the datapath for as_A/as_B/as_sub_or_add.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  downstream accepts; the result pops on an edge where out_valid & out_ready.
- out_S  out  32  captured result.
- out_tag  out  TAG_W  tag of the captured result.
- count  out  CW  FIFO occupancy (excludes the issue and result stages).

## Operation
- FIFO: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a registered count.
  - push = in_valid & in_ready.
  - pop = (count != 0) & issue_adv.
  - count updates as count + push − pop.
- Issue stage (iss_v plus registered A, B, sub, tag):
  - issue_adv = !iss_v | res_adv.
  - On issue_adv, iss_v ← (count != 0), and the FIFO head loads into the issue register.
  - The issue register holds its value while stalled, so as_* stay stable under backpressure.
- Result stage (res_v plus registered S, tag):
  - res_adv = !res_v | out_ready.
  - On res_adv, res_v ← iss_v, out_S ← as_S and out_tag ← iss_tag.
  - When the issue stage advances, it has always emptied into the result stage in the same edge.
- The FIFO has no bypass. A request accepted on edge E0 becomes the head after E0.
- Full: in_ready = 0 regardless of a same-cycle pop, so push and pop never conflict at full.
- Empty: no pop. The issue stage loads iss_v = 0 when it advances.
- Simultaneous push and pop at mid occupancy: count is unchanged and both pointers advance.
- flush:
  - pointers, count, iss_v and res_v are all set to 0 on that edge.
  - A request presented in the same cycle is dropped: in_ready is still evaluated, but the push is discarded.
  - flush has priority over every other update.
- Data registers (FIFO storage, operands, out_S, out_tag) need not be reset. The valid bits, pointers and count must be reset.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, count = 0.
  - as_A = 0, as_B = 0, as_sub_or_add = 0.
  - out_S = 0, out_tag = 0.
  - Internally iss_v = 0.
- Latency:
  - A request accepted at E0 loads the issue register at E1 and the result register at E2.
  - out_valid is high in the cycle after E2, provided out_ready was high or the stages were empty.
- Throughput is one result per cycle while out_ready = 1 and in_valid = 1 continuously.
- Capacity is DEPTH + 2 requests in flight (FIFO, issue stage and result stage).
- out_valid, once asserted, stays high with stable out_S/out_tag until popped, flush or rst.
- Reset mid-operation asynchronously clears all valid state. Results in flight are lost with no partial output.

## Test plan
- After reset, push A=0x3F800000, B=0x40000000, sub=0, tag=1 with out_ready=1.
  - Required: out_valid rises 2 edges after accept with out_S=0x40400000, out_tag=1, and count returns to 0.
- Push A=0x40400000, B=0x3F800000, sub=1, tag=2.
  - Required: out_S=0x40000000, out_tag=2.
- Hold out_ready=0 and push 7 requests back-to-back with DEPTH=4.
  - Required: 6 are accepted (result, issue and 4 FIFO entries), in_ready drops with count=4, and as_*/out_S stay stable.
  - Then raise out_ready: results emerge one per cycle in tag order.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with incrementing tags.
  - Required: one result per cycle, tags in order with no gaps, and the pointers wrap correctly past DEPTH.
- Assert flush with 3 entries queued, the issue stage full and the result stage full.
  - Required: next cycle out_valid=0, count=0, in_ready=1, and no stale results appear afterwards.
- Assert rst asynchronously mid-stream.
  - Required: out_valid=0 and count=0 immediately without waiting for a clock edge, and normal operation after rst deasserts.
